// File: rtl/cu_pkg.sv
// Shared decode definitions for the RV32I main control unit.
package cu_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_NE    = 4'b1011,
        ALU_LT    = 4'b1100,
        ALU_GE    = 4'b1101,
        ALU_LTU   = 4'b1110,
        ALU_GEU   = 4'b1111
    } alu_op_t;

    typedef struct packed {
        logic mem_to_reg;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    // Arithmetic/logic op selected by funct3; alt picks SUB/SRA variants.
    function automatic alu_op_t arith_op(input logic [FUNCT3_W-1:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I main decoder: instruction -> strobes, ALU op, illegal flag.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl_c,
    output alu_op_t     alu_op_c,
    output logic        illegal_c
);

    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic                unused_fields;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    // Register specifiers play no part in control decode.
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    // Opcode/funct decode; any unsupported encoding collapses to a bubble.
    always_comb begin
        ctrl_c    = '0;
        alu_op_c  = ALU_AND;
        illegal_c = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_c.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    alu_op_c = arith_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_op_c = arith_op(funct3, 1'b1);
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OP_IMM: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) alu_op_c = ALU_SLL;
                        else                   illegal_c = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     alu_op_c = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op_c = ALU_SRA;
                        else                       illegal_c = 1'b1;
                    end
                    default: alu_op_c = arith_op(funct3, 1'b0);
                endcase
            end
            OP_LOAD: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                alu_op_c          = ALU_ADD;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_c = 1'b0;
                    default:                                 illegal_c = 1'b1;
                endcase
            end
            OP_STORE: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                alu_op_c         = ALU_ADD;
                case (funct3)
                    3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
                    default:                illegal_c = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                ctrl_c.branch = 1'b1;
                case (funct3)
                    3'b000:  alu_op_c = ALU_SUB;
                    3'b001:  alu_op_c = ALU_NE;
                    3'b100:  alu_op_c = ALU_LT;
                    3'b101:  alu_op_c = ALU_GE;
                    3'b110:  alu_op_c = ALU_LTU;
                    3'b111:  alu_op_c = ALU_GEU;
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_LUI: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_src   = 1'b1;
                alu_op_c         = ALU_PASSB;
            end
            default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
            ctrl_c   = '0;
            alu_op_c = ALU_AND;
        end
    end

endmodule

// File: rtl/control_unit.sv
// RV32I main control unit: decoded controls registered once on clk.
// Define CU_ILLEGAL_DETECT_EN to add the registered 'illegal' output.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [3:0]  ALUOp,
    output logic        MemtoReg,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite
`ifdef CU_ILLEGAL_DETECT_EN
    ,
    output logic        illegal
`endif
);

    ctrl_t   ctrl_c;
    alu_op_t alu_op_c;
    logic    illegal_c;
    ctrl_t   ctrl_q;
    alu_op_t alu_op_q;

    cu_decode u_decode (
        .instruction (instruction),
        .ctrl_c      (ctrl_c),
        .alu_op_c    (alu_op_c),
        .illegal_c   (illegal_c)
    );

    // Output register; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            alu_op_q <= ALU_AND;
        end else begin
            ctrl_q   <= ctrl_c;
            alu_op_q <= alu_op_c;
        end
    end

`ifdef CU_ILLEGAL_DETECT_EN
    logic illegal_q;

    // Unsupported-encoding flag, same latency as the controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_c;
    end

    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_c;
`endif

    assign ALUOp    = ALU_OP_W'(alu_op_q);
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign Branch   = ctrl_q.branch;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign ALUSrc   = ctrl_q.alu_src;
    assign RegWrite = ctrl_q.reg_write;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (both CU_ILLEGAL_DETECT_EN builds).
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [3:0]  ALUOp;
    logic        MemtoReg, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
`ifdef CU_ILLEGAL_DETECT_EN
    logic        illegal;
`endif

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .ALUOp       (ALUOp),
        .MemtoReg    (MemtoReg),
        .Branch      (Branch),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite)
`ifdef CU_ILLEGAL_DETECT_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {illegal, ALUOp, MemtoReg, Branch, MemRead, MemWrite, ALUSrc, RegWrite}.
    function automatic logic [10:0] observed();
        logic ill;
`ifdef CU_ILLEGAL_DETECT_EN
        ill = illegal;
`else
        ill = 1'b0;
`endif
        return {ill, ALUOp, MemtoReg, Branch, MemRead, MemWrite, ALUSrc, RegWrite};
    endfunction

    // Expected outputs; the illegal bit only exists in the detect build.
    function automatic logic [10:0] expect_of(input logic [3:0] op, input logic [5:0] strobes,
                                              input logic ill);
`ifdef CU_ILLEGAL_DETECT_EN
        return {ill, op, strobes};
`else
        return {1'b0 & ill, op, strobes};
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Strobe order: MemtoReg, Branch, MemRead, MemWrite, ALUSrc, RegWrite.
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [5:0]  strobes;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [10:0] prev_exp;
    logic [10:0] cur_exp;

    initial begin
        vecs.push_back('{32'h00007633, 4'b0000, 6'b000001, 1'b0, "and"});
        vecs.push_back('{32'h40B58633, 4'b0110, 6'b000001, 1'b0, "sub"});
        vecs.push_back('{32'h00B58663, 4'b0110, 6'b010000, 1'b0, "beq"});
        vecs.push_back('{32'h00B59663, 4'b1011, 6'b010000, 1'b0, "bne"});
        vecs.push_back('{32'h00B5A623, 4'b0010, 6'b000110, 1'b0, "sw"});
        vecs.push_back('{32'h00B5A603, 4'b0010, 6'b101011, 1'b0, "lw"});
        vecs.push_back('{32'h00B58637, 4'b1010, 6'b000011, 1'b0, "lui"});
        vecs.push_back('{32'h40000013, 4'b0010, 6'b000011, 1'b0, "addi_b30"});
        vecs.push_back('{32'h00000000, 4'b0000, 6'b000000, 1'b1, "zero_word"});
        vecs.push_back('{32'h02B58633, 4'b0000, 6'b000000, 1'b1, "r_f7_01"});
        vecs.push_back('{32'h00B5C663, 4'b1100, 6'b010000, 1'b0, "blt"});
        vecs.push_back('{32'h00B5F663, 4'b1111, 6'b010000, 1'b0, "bgeu"});
        vecs.push_back('{32'h4015D613, 4'b0111, 6'b000011, 1'b0, "srai"});
        vecs.push_back('{32'h40159613, 4'b0000, 6'b000000, 1'b1, "slli_f7alt"});
        vecs.push_back('{32'h00B5A663, 4'b0000, 6'b000000, 1'b1, "branch_f3_010"});
        vecs.push_back('{32'h00B5B623, 4'b0000, 6'b000000, 1'b1, "store_f3_011"});
        vecs.push_back('{32'h00B5E603, 4'b0000, 6'b000000, 1'b1, "load_f3_110"});
        vecs.push_back('{32'h00B5C603, 4'b0010, 6'b101011, 1'b0, "lbu"});
        vecs.push_back('{32'h0015B613, 4'b1001, 6'b000011, 1'b0, "sltiu"});
        vecs.push_back('{32'h40B5A633, 4'b0000, 6'b000000, 1'b1, "slt_f7alt"});
        vecs.push_back('{32'h00B5D633, 4'b0101, 6'b000001, 1'b0, "srl"});
        vecs.push_back('{32'h40B5D633, 4'b0111, 6'b000001, 1'b0, "sra"});
        vecs.push_back('{32'h00B59633, 4'b0100, 6'b000001, 1'b0, "sll"});
        vecs.push_back('{32'h00B5C633, 4'b0011, 6'b000001, 1'b0, "xor"});
        vecs.push_back('{32'h00B5A633, 4'b1000, 6'b000001, 1'b0, "slt"});
        vecs.push_back('{32'hFFFFFFFF, 4'b0000, 6'b000000, 1'b1, "opcode_ones"});
        vecs.push_back('{32'h00B5A623, 4'b0010, 6'b000110, 1'b0, "sw_again"});

        // Reset held with a legal instruction and clock running.
        rst = 1'b1;
        instruction = 32'h00B5E633;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_hold", observed(), expect_of(4'b0000, 6'b000000, 1'b0));

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_release_no_edge", observed(), expect_of(4'b0000, 6'b000000, 1'b0));
        @(posedge clk);
        #1;
        prev_exp = expect_of(4'b0001, 6'b000001, 1'b0);
        check_eq("or_first", observed(), prev_exp);

        // Each vector: outputs hold before the edge, update one cycle after.
        foreach (vecs[i]) begin
            @(negedge clk);
            instruction = vecs[i].instr;
            #1;
            check_eq({vecs[i].name, "_hold"}, observed(), prev_exp);
            @(posedge clk);
            #1;
            cur_exp = expect_of(vecs[i].op, vecs[i].strobes, vecs[i].ill);
            check_eq(vecs[i].name, observed(), cur_exp);
            prev_exp = cur_exp;
        end

        // Asynchronous reset mid-stream, away from any rising edge.
        @(negedge clk);
        instruction = 32'h00B5A603;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset", observed(), expect_of(4'b0000, 6'b000000, 1'b0));
        @(posedge clk);
        #1;
        check_eq("async_reset_hold", observed(), expect_of(4'b0000, 6'b000000, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("lw_after_reset", observed(), expect_of(4'b0010, 6'b101011, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the single-issue RV32I core.
- Maps a 32-bit instruction word to a 4-bit ALU operation code and six datapath control strobes: MemtoReg, Branch, MemRead, MemWrite, ALUSrc, RegWrite.
- Decode is combinational from opcode/funct3/funct7; all outputs are registered once on the core clock.
- Sits between the instruction register and the ALU, register file and data-memory controls.

Parameters:
- None. The RV32I encoding and 4-bit ALUOp width are fixed.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  32  instruction word to decode.
- ALUOp  output  4  registered ALU operation code.
- MemtoReg  output  1  write-back selects data memory (1) or ALU result (0).
- Branch  output  1  instruction is a conditional branch.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- ALUSrc  output  1  ALU operand B is the immediate (1) or rs2 (0).
- RegWrite  output  1  register-file write enable.

Behaviour:
- Latency: outputs reflect the instruction sampled at the previous rising clk edge (1 cycle).
- No handshake; a new instruction may be presented every cycle.
- Reset: rst=1 immediately forces all outputs to 0 (ALUOp=4'b0000), independent of clk, and holds them while asserted. The first decode happens on the first rising edge after rst deasserts.
- Field extraction: opcode=[6:0], funct3=[14:12], funct7=[31:25]. rd/rs fields are ignored; rd=x0 still yields RegWrite=1 (the register file discards x0 writes).
- ALUOp codes:
  - Arithmetic/logic: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
  - Branch compares: NE 1011, LT 1100, GE 1101, LTU 1110, GEU 1111.
- Per-opcode decode (any strobe not listed is 0):
  - R-type 0110011: RegWrite=1, ALUSrc=0.
    - ALUOp from funct3: 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND.
    - funct7=0100000 is legal only with funct3 000/101. Any other funct7 besides 0000000 is unsupported.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, same funct3 mapping.
    - funct7 is ignored except for shifts: funct3 001 needs funct7=0000000; funct3 101 gives SRL for 0000000, SRA for 0100000, otherwise unsupported.
    - ADDI never decodes as SUB.
  - Load 0000011: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=1, ALUOp=ADD. Legal funct3: 000, 001, 010, 100, 101.
  - Store 0100011: ALUSrc=1, MemWrite=1, ALUOp=ADD. Legal funct3: 000, 001, 010.
  - Branch 1100011: Branch=1, ALUSrc=0. ALUOp by funct3: 000 SUB (BEQ), 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. funct3 010/011 unsupported.
  - LUI 0110111: RegWrite=1, ALUSrc=1, ALUOp=PASSB.
- Unsupported or unlisted opcode/funct combination: registered as a bubble — all strobes 0, ALUOp=0000. No write or memory side effects.
- instruction=X/Z: no requirement beyond the outputs never asserting MemWrite or RegWrite for an all-zero word (opcode 0000000 is unsupported).

Optional Feature:
- Macro: CU_ILLEGAL_DETECT_EN.
- When defined: adds output port illegal (1 bit), registered with the same 1-cycle latency. It is 1 for every unsupported encoding listed above, cleared to 0 by rst.
- When undefined: no port is added; unsupported encodings still decode as a bubble.

Decomposition:
- Package cu_pkg holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI;
  - the 4-bit ALUOp localparams, typedef'd as an alu_op_t enum;
  - a ctrl_t struct bundling the six strobes.
- One combinational sub-module, cu_decode (instruction -> ctrl_t + alu_op_t + illegal).
- control_unit wraps cu_decode with the async-reset output register.

Test Plan:
- rst=1 with instruction=0x00B5E633 and clk toggling -> all outputs 0. Deassert rst; next edge -> RegWrite=1, ALUOp=0001 (OR), others 0.
- 0x00007633 (AND), then 0x40B58633 (SUB) on consecutive cycles -> ALUOp 0000 then 0110, each one cycle after its edge; RegWrite=1, ALUSrc=0.
- 0x00B58663 (BEQ) -> Branch=1, ALUOp=0110, RegWrite=0. Then 0x00B59663 (BNE) -> Branch=1, ALUOp=1011.
- 0x00B5A623 (SW) -> MemWrite=1, ALUSrc=1, ALUOp=0010, RegWrite=0. Then 0x00B5A603 (LW) -> MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=1, ALUOp=0010.
- 0x00B58637 (LUI) -> RegWrite=1, ALUSrc=1, ALUOp=1010. 0x40000013 (ADDI with bit30 set) -> ALUOp=0010, not SUB.
- 0x00000000 and 0x02B58633 (funct7=0000001) -> all outputs 0; illegal=1 when CU_ILLEGAL_DETECT_EN is defined. Asserting rst mid-stream clears outputs without waiting for a clk edge.
